// File: rtl/pending_enc_pkg.sv
// Shared types and helpers for pending_req_encoder.
// PENDING_ENC_ROUND_ROBIN_EN selects rotating priority.
package pending_enc_pkg;

  localparam int N_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [6:0] popcount(
    input logic [63:0] v
  );
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++)
      c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/prio_encoder.sv
// Priority encoder searching upward from start,
// wrapping at N; lowest offset from start wins.
module prio_encoder #(
  parameter int N  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [AW-1:0] start,
  output logic [AW-1:0] idx,
  output logic          any
);

  logic [AW-1:0] p;

  always_comb begin
    idx = '0;
    any = 1'b0;
    p   = '0;
    // Scan from the far end so the nearest hit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      p = start + AW'(k);
      if (vec[p]) begin
        idx = p;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_req_encoder.sv
// Pending write-request encoder with valid/ready offer.
// PENDING_ENC_ROUND_ROBIN_EN enables rotating priority.
module pending_req_encoder
  import pending_enc_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_in,
  input  logic          ready_in,
  output logic [AW-1:0] addr_out,
  output logic          valid_out,
  output logic [AW:0]   pend_count
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [N-1:0]  clr;
  logic          accept;
  logic [AW-1:0] start;
  logic [AW-1:0] sel_idx;
  logic          sel_any;

  assign accept = (state_q == OFFER) && ready_in;

  always_comb begin
    clr    = accept ? (N'(1) << addr_q) : '0;
    pend_d = (pend_q & ~clr) | req_in;
    cnt_d  = (AW+1)'(popcount(64'(pend_d)));
  end

`ifdef PENDING_ENC_ROUND_ROBIN_EN
  logic [AW-1:0] last_q, last_d;

  // Search starts just past the address granted most recently.
  always_comb begin
    last_d = accept ? addr_q : last_q;
    start  = last_d + AW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= AW'(N - 1);
    else       last_q <= last_d;
  end
`else
  assign start = '0;
`endif

  prio_encoder #(
    .N  (N),
    .AW (AW)
  ) u_prio (
    .vec   (pend_d),
    .start (start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          state_d = OFFER;
          addr_d  = sel_idx;
        end
      end
      OFFER: begin
        if (accept) begin
          if (sel_any) addr_d  = sel_idx;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out  = (state_q == OFFER);
  assign addr_out   = addr_q;
  assign pend_count = cnt_q;

endmodule

// File: tb/tb_pending_req_encoder.sv
// Directed bench for pending_req_encoder.
// Honors PENDING_ENC_ROUND_ROBIN_EN for the starvation case.
module tb_pending_req_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_in;
  logic        ready_in;
  logic [4:0]  addr_out;
  logic        valid_out;
  logic [5:0]  pend_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  pending_req_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_in),
    .ready_in   (ready_in),
    .addr_out   (addr_out),
    .valid_out  (valid_out),
    .pend_count (pend_count)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_offer(
    input string      tag,
    input logic [4:0] a,
    input logic [5:0] c
  );
    check({tag, "_v"}, 32'(valid_out), 32'd1);
    check({tag, "_a"}, 32'(addr_out), 32'(a));
    check({tag, "_c"}, 32'(pend_count), 32'(c));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_v"}, 32'(valid_out), 32'd0);
    check({tag, "_c"}, 32'(pend_count), 32'd0);
  endtask

  initial begin
    logic [4:0] rr_seq [4];
    rr_seq = '{5'd0, 5'd2, 5'd0, 5'd2};

    reset    = 1'b1;
    req_in   = 32'h0000_0005;
    ready_in = 1'b0;
    tick();
    tick();
    expect_idle("rst");
    reset = 1'b0;
    tick();
    expect_offer("rel", 5'd0, 6'd2);
    req_in   = '0;
    ready_in = 1'b1;
    tick();
    expect_offer("rel2", 5'd2, 6'd1);
    tick();
    expect_idle("rel3");

    req_in = 32'h8000_0011;
    tick();
    expect_offer("b2b0", 5'd0, 6'd3);
    req_in = '0;
    tick();
    expect_offer("b2b4", 5'd4, 6'd2);
    tick();
    expect_offer("b2b31", 5'd31, 6'd1);
    tick();
    expect_idle("b2bend");

    ready_in = 1'b0;
    req_in   = 32'h0000_0020;
    tick();
    expect_offer("hold5", 5'd5, 6'd1);
    req_in = 32'h0000_0002;
    tick();
    expect_offer("hold5b", 5'd5, 6'd2);
    req_in = '0;
    tick();
    expect_offer("hold5c", 5'd5, 6'd2);
    ready_in = 1'b1;
    tick();
    expect_offer("then1", 5'd1, 6'd1);
    tick();
    expect_idle("hold_end");

    ready_in = 1'b0;
    req_in   = 32'h0000_0008;
    tick();
    expect_offer("re3", 5'd3, 6'd1);
    ready_in = 1'b1;
    tick();
    expect_offer("re3b", 5'd3, 6'd1);
    req_in = '0;
    tick();
    expect_idle("re3_end");

    req_in = 32'h0000_0005;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef PENDING_ENC_ROUND_ROBIN_EN
      check("seq_a", 32'(addr_out), 32'(rr_seq[i]));
`else
      check("seq_a", 32'(addr_out), 32'd0);
`endif
      check("seq_v", 32'(valid_out), 32'd1);
    end
    req_in = '0;
    tick();
    tick();
    tick();
    expect_idle("seq_end");

    ready_in = 1'b0;
    req_in   = 32'h0000_000E;
    tick();
    expect_offer("pre_rst", 5'd1, 6'd3);
    req_in = '0;
    #2;
    reset = 1'b1;
    #1;
    expect_idle("async_rst");
    tick();
    reset    = 1'b0;
    ready_in = 1'b1;
    tick();
    tick();
    tick();
    expect_idle("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pending_req_encoder.md
# pending_req_encoder

Converts a multi-hot vector of register write requests into a stream of binary register addresses, one per accepted handshake. It is the encoding counterpart of the register-file write-select decoder. Upstream sources pulse bits of `req_in`. The block records them as pending and offers them one at a time, as `addr_out` with `valid_out`, to the register-file write port, which accepts each with `ready_in`.

## Interface
- `N`, 32: number of request lines / registers; power of two, 2..64
- `AW`, $clog2(N): address width
- `clk`  in  1  rising-edge clock; the block's single clock domain
- `reset`  in  1  asynchronous, active-high; clears all state
- `req_in`  in  N  request pulses; bit i set for one or more cycles marks register i pending
- `ready_in`  in  1  consumer accepts `addr_out` when `valid_out && ready_in` at a rising edge
- `addr_out`  out  AW  binary index of the offered register; reset 0
- `valid_out`  out  1  offer valid; reset 0
- `pend_count`  out  AW+1  number of set bits in the pending register, including the offered one; reset 0

## Operation
- Pending register `pend_q[N-1:0]` and the accept pulse:
  - `accept = valid_out && ready_in`
  - `clr = accept ? onehot(addr_q) : 0`
  - `pend_d = (pend_q & ~clr) | req_in`
- A request on the bit being accepted in the same cycle stays pending, so no request is lost. Repeated requests on an already-pending bit merge into one.
- FSM has two states, IDLE and OFFER. `valid_out = (state == OFFER)`; `addr_out = addr_q`.
  - IDLE → OFFER when `pend_d != 0`; latch `addr_q = select(pend_d)`.
  - OFFER with `!accept`: hold `addr_q` and stay in OFFER. The address must not change while offered, even if a higher-priority bit arrives.
  - OFFER with `accept` and `pend_d != 0`: latch `addr_q = select(pend_d)` and stay in OFFER. This gives back-to-back throughput of one address per cycle.
  - OFFER with `accept` and `pend_d == 0`: go to IDLE; `addr_q` holds its last value.
- `select()` is fixed-priority lowest index, unless the round-robin option below is compiled in.
- `pend_count` is the population count of `pend_q`, registered with it.
- Reset mid-offer: `valid_out` drops immediately (asynchronously) and all pending bits are lost.

## Timing
- Latency from request to offer: `req_in[i]` high in cycle k, with the block idle, gives `valid_out = 1` and `addr_out = i` in cycle k+1.
- On accept at the edge ending cycle k, the next address, if any, is offered in cycle k+1. There are no bubbles.
- All outputs come directly from flops; there are no combinational paths from input to output.
- `ready_in` may be asserted before `valid_out`; it has no effect while `valid_out = 0`.

## Configuration
- `PENDING_ENC_ROUND_ROBIN_EN`
- Defined: `select()` searches upward, wrapping around, starting at `(last_accepted + 1) mod N`. `last_accepted` resets to N-1, so the first search starts at 0.
- Not defined: strict lowest-index priority. A continuously re-requested low bit may starve higher bits.

## Structure
- Package `pending_enc_pkg` holds the state enum (IDLE, OFFER) and the default `N`. `AW` is derived from `N` in the module itself.
- Sub-module `prio_encoder`, parameterized by `N`. Inputs: `vec[N-1:0]` and `start[AW-1:0]`. Outputs: `idx[AW-1:0]` and `any`. It is combinational; fixed-priority mode ties `start` to 0.
- The population count is a function in the package.

## Test plan
- Reset with `req_in = 32'h0000_0005` held → `valid_out = 0`, `pend_count = 0`. Release reset → cycle 1: `addr_out = 0`, `pend_count = 2`.
- `req_in = 32'h8000_0011` for one cycle, `ready_in = 1` → `addr_out` = 0, 4, 31 in consecutive cycles, then `valid_out = 0`, `pend_count = 0`.
- Offer `addr_out = 5` with `ready_in = 0`, then pulse `req_in[1]` → `addr_out` stays 5 until accepted, then 1 is offered.
- Accept `addr_out = 3` in the same cycle `req_in[3] = 1` → next cycle `addr_out = 3` again and `pend_count` is unchanged.
- With `PENDING_ENC_ROUND_ROBIN_EN`: hold `req_in[0]` and `req_in[2]` high with `ready_in = 1` → the sequence alternates 0, 2, 0, 2. Without the macro, the sequence is 0, 0, 0, ….
- Assert `reset` mid-offer with `pend_count = 3` → `valid_out` falls before the next edge. After release with `req_in = 0`, the block stays in IDLE.
